// File: rtl/mips_boot_loader.sv
// rtl/mips_boot_loader.sv - byte-stream program loader for pipe_MIPS32 instruction memory
// Frame: A5, LEN_HI, LEN_LO, 4*N data bytes (MSB first), XOR checksum of everything after A5.
module mips_boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              cpu_halted,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic [ADDR_W-1:0] start_pc,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]  SYNC      = 8'hA5;
    localparam logic [32:0] ADDR_SPAN = 33'd1 << ADDR_W;

    state_t      r_state;
    logic [7:0]  r_len_hi;
    logic [7:0]  r_chk;
    logic [15:0] r_len;
    logic [15:0] r_word_cnt;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_shift;

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_len_bad;
    logic [31:0] w_word;

    assign w_accept  = in_valid & in_ready;
    assign w_len     = {r_len_hi, in_data};
    assign w_word    = {r_shift, in_data};
    assign w_len_bad = (w_len == 16'd0)
                     || (32'(w_len) > 32'(MAX_WORDS))
                     || (33'(BASE_ADDR) + 33'(w_len) > ADDR_SPAN);

    // After a good load, new bytes are only taken once the processor has halted again.
    assign in_ready = (r_state == S_DONE) ? cpu_halted : 1'b1;
    assign start_pc = ADDR_W'(BASE_ADDR);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len_hi   <= 8'd0;
            r_chk      <= 8'd0;
            r_len      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 24'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            cpu_start  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            cpu_start <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE, S_ERR, S_DONE: begin
                        if (in_data == SYNC) begin
                            r_state   <= S_LEN_HI;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            r_chk     <= 8'd0;
                        end
                    end
                    S_LEN_HI: begin
                        r_len_hi <= in_data;
                        r_chk    <= r_chk ^ in_data;
                        r_state  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        r_len      <= w_len;
                        r_chk      <= r_chk ^ in_data;
                        r_word_cnt <= 16'd0;
                        r_byte_idx <= 2'd0;
                        if (w_len_bad) begin
                            r_state  <= S_ERR;
                            load_err <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_chk      <= r_chk ^ in_data;
                        r_shift    <= {r_shift[15:0], in_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            mem_we     <= 1'b1;
                            mem_wdata  <= w_word;
                            mem_addr   <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_word_cnt);
                            r_word_cnt <= r_word_cnt + 16'd1;
                            if (r_word_cnt + 16'd1 == r_len) begin
                                r_state <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (in_data == r_chk) begin
                            r_state   <= S_DONE;
                            cpu_start <= 1'b1;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            r_state  <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_boot_loader.sv
// tb/tb_mips_boot_loader.sv - scoreboard bench for mips_boot_loader
// Stimulus pushes expected writes/starts/status into queues; a negedge monitor pops and compares.
module tb_mips_boot_loader;

    localparam int ADDR_W = 10;
    localparam int BASE   = 0;
    localparam int MAXW   = 1024;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              cpu_halted;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic [ADDR_W-1:0] start_pc;
    logic              load_done;
    logic              load_err;

    mips_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cpu_halted(cpu_halted),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .cpu_start (cpu_start),
        .start_pc  (start_pc),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        string name;
        bit    rstchk;
        logic  hold;
        logic  done;
        logic  err;
        logic  ready;
    } st_t;

    wr_t         wr_q[$];
    bit          start_q[$];
    st_t         st_q[$];
    logic [31:0] frame_w[$];
    logic [7:0]  garb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          drv_to   = 0;

    initial begin : monitor
        wr_t  e;
        st_t  s;
        bit   prev_we;
        bit   ok;
        prev_we = 1'b0;
        forever begin
            @(negedge clk1);
            if (!rst) begin
                if (mem_we) begin
                    n_checks++;
                    if (wr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: got addr=%0h data=%h, required no write", mem_addr, mem_wdata);
                    end else begin
                        e = wr_q.pop_front();
                        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                            n_fail++;
                            $display("FAIL write: got addr=%0h data=%h, required addr=%0h data=%h",
                                     mem_addr, mem_wdata, e.addr, e.data);
                        end
                    end
                    n_checks++;
                    if (prev_we) begin
                        n_fail++;
                        $display("FAIL we_width: mem_we high 2 cycles, required 1");
                    end
                end
                if (cpu_start) begin
                    n_checks++;
                    if (start_q.size() == 0 || mem_we) begin
                        n_fail++;
                        $display("FAIL start: got cpu_start=1 mem_we=%b pending=%0d, required expected lone pulse",
                                 mem_we, start_q.size());
                    end else begin
                        void'(start_q.pop_front());
                    end
                end
            end
            prev_we = !rst && mem_we;
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                n_checks++;
                ok = cpu_hold === s.hold && load_done === s.done && load_err === s.err
                     && in_ready === s.ready && drv_to == 0;
                if (!s.rstchk)
                    ok = ok && wr_q.size() == 0 && start_q.size() == 0;
                else
                    ok = ok && mem_we === 1'b0 && mem_addr === '0 && mem_wdata === 32'd0
                         && cpu_start === 1'b0 && start_pc === ADDR_W'(BASE);
                if (!ok) begin
                    n_fail++;
                    $display("FAIL %s: got hold/done/err/ready=%b%b%b%b we=%b addr=%0h wdata=%h start=%b pend_wr=%0d pend_start=%0d timeouts=%0d, required %b%b%b%b%s",
                             s.name, cpu_hold, load_done, load_err, in_ready, mem_we, mem_addr, mem_wdata,
                             cpu_start, wr_q.size(), start_q.size(), drv_to, s.hold, s.done, s.err, s.ready,
                             s.rstchk ? " with we/addr/wdata/start zero" : " with nothing pending");
                end
            end
        end
    end

    task automatic push_st(input string name, input bit rc, input logic h, input logic d,
                           input logic er, input logic rd);
        st_t s;
        s.name = name; s.rstchk = rc; s.hold = h; s.done = d; s.err = er; s.ready = rd;
        st_q.push_back(s);
    endtask

    task automatic drain();
        int w = 0;
        while (st_q.size() != 0 && w < 100) begin
            @(negedge clk1);
            w++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        int w = 0;
        repeat (g) begin
            in_valid = 1'b0;
            @(negedge clk1);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && w < 200) begin
            @(negedge clk1);
            w++;
        end
        if (!in_ready) drv_to++;
        @(negedge clk1);
    endtask

    // Reference model: frame bytes and outcome follow directly from the frame rules.
    task automatic run_frame(input string name, input int n_len, input int chk_x,
                             input int max_gap, input bit skip_sync);
        logic [7:0] bytes[$];
        logic [7:0] chk;
        bit         len_ok;
        wr_t        e;
        len_ok = n_len >= 1 && n_len <= MAXW && BASE + n_len <= (1 << ADDR_W);
        foreach (garb_q[i]) bytes.push_back(garb_q[i]);
        if (!skip_sync) bytes.push_back(8'hA5);
        bytes.push_back(8'(n_len >> 8));
        bytes.push_back(8'(n_len));
        chk = 8'(n_len >> 8) ^ 8'(n_len);
        if (len_ok) begin
            for (int i = 0; i < n_len; i++) begin
                for (int k = 3; k >= 0; k--) begin
                    bytes.push_back(8'(frame_w[i] >> (8 * k)));
                    chk ^= 8'(frame_w[i] >> (8 * k));
                end
                e.addr = ADDR_W'(BASE + i);
                e.data = frame_w[i];
                wr_q.push_back(e);
            end
            bytes.push_back(chk ^ 8'(chk_x));
            if (chk_x == 0) start_q.push_back(1'b1);
        end
        foreach (bytes[i]) send_byte(bytes[i], max_gap);
        in_valid = 1'b0;
        repeat (2) @(negedge clk1);
        if (len_ok && chk_x == 0) push_st(name, 1'b0, 1'b0, 1'b1, 1'b0, cpu_halted);
        else                      push_st(name, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drain();
    endtask

    initial begin : stimulus
        logic [7:0] b;
        int         n;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; cpu_halted = 1'b1;
        repeat (2) @(negedge clk1);
        push_st("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();
        rst = 1'b0;
        @(negedge clk1);

        frame_w = '{32'h2801000A, 32'h28020014};
        run_frame("good_2word", 2, 0, 0, 1'b0);
        run_frame("bad_chk_1E", 2, 1, 0, 1'b0);
        frame_w.delete();
        run_frame("len_zero", 0, 0, 0, 1'b0);
        run_frame("len_1025", 1025, 0, 0, 1'b0);

        garb_q  = '{8'h00, 8'hFF, 8'h12};
        frame_w = '{32'h2801000A, 32'h28020014, 32'h2803001E, 32'h00222000, 32'h00832800,
                    32'h00A33000, 32'h00C43800, 32'h04E54000, 32'hFC000000};
        run_frame("mips9_gaps", 9, 0, 3, 1'b0);
        garb_q.delete();

        cpu_halted = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) @(negedge clk1);
        push_st("done_not_halted", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        cpu_halted = 1'b1;
        @(negedge clk1);
        in_valid = 1'b0;
        push_st("reload_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();
        frame_w = '{32'h12345678};
        run_frame("reload_body", 1, 0, 1, 1'b1);

        for (int t = 0; t < 10; t++) begin
            frame_w.delete();
            garb_q.delete();
            repeat ($urandom_range(3, 0)) begin
                do b = 8'($urandom); while (b == 8'hA5);
                garb_q.push_back(b);
            end
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) frame_w.push_back($urandom);
            if ($urandom_range(5, 0) == 0) n = ($urandom_range(1, 0) == 1) ? 0 : int'($urandom_range(1500, 1025));
            run_frame("random", n, ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 1)) : 0,
                      int'($urandom_range(2, 0)), 1'b0);
        end
        garb_q.delete();

        frame_w.delete();
        for (int i = 0; i < 4; i++) frame_w.push_back($urandom);
        for (int i = 0; i < 2; i++) wr_q.push_back('{ADDR_W'(BASE + i), frame_w[i]});
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
        for (int i = 0; i < 2; i++)
            for (int k = 3; k >= 0; k--) send_byte(8'(frame_w[i] >> (8 * k)), 0);
        in_valid = 1'b0;
        @(posedge clk1);
        #1 rst = 1'b1;
        wr_q.delete();
        push_st("async_reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();
        @(negedge clk1);
        rst = 1'b0;
        for (int i = 2; i < 4; i++)
            for (int k = 3; k >= 0; k--) begin
                b = 8'(frame_w[i] >> (8 * k));
                send_byte((b == 8'hA5) ? 8'h5A : b, 0);
            end
        send_byte(8'h3C, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk1);
        push_st("after_reset_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        frame_w = '{32'hDEADBEEF, 32'h0000A5A5, 32'hA5000000};
        run_frame("recovery", 3, 0, 1, 1'b0);

        repeat (2) @(negedge clk1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Upstream loader for pipe_MIPS32: receives a byte stream carrying a program image and writes assembled 32-bit instruction words into the processor's instruction/data memory.
- Holds the processor halted while loading; releases it with a one-cycle start pulse, and PC restarts at BASE_ADDR.
- Replaces hierarchical Mem/PC/HALTED pokes with a synthesizable load path.

Parameters:
- ADDR_W, 10, memory word-address width (1024-word Mem).
- BASE_ADDR, 0, first word address written; also the PC restart value.
- MAX_WORDS, 1024, largest accepted image length in words.

Ports:
- clk1  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts byte; transfer occurs when in_valid & in_ready on a rising edge.
- cpu_halted  in  1  processor HALTED flag; gates reload.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  instruction word.
- cpu_hold  out  1  keeps the processor halted while high.
- cpu_start  out  1  one-cycle pulse: processor sets PC=BASE_ADDR, clears HALTED and TAKEN_BRANCH.
- start_pc  out  ADDR_W  constant BASE_ADDR.
- load_done  out  1  sticky: last image loaded and verified.
- load_err  out  1  sticky: last image rejected.

Behaviour:
- Reset values (async on rst high): state IDLE, cpu_hold=1, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_start=0, load_done=0, load_err=0. Internal word count, byte index and checksum are 0.
- Frame format: SYNC 0xA5, LEN_HI, LEN_LO (N words, big-endian), then 4N data bytes (MSB first per word), then CHK = XOR of LEN and data bytes (SYNC excluded).
- IDLE: non-0xA5 bytes are accepted and discarded. On 0xA5: cpu_hold=1, load_done=0, load_err=0, checksum cleared, go to LEN_HI.
- LEN_HI -> LEN_LO. After LEN_LO: if N==0 or N>MAX_WORDS or BASE_ADDR+N>2^ADDR_W, go to ERR; else go to DATA.
- DATA: shift bytes into a 32-bit assembly register. When the 4th byte of a word is accepted, on the next edge mem_we=1, mem_wdata=word, mem_addr=BASE_ADDR+word_index. mem_we is high for exactly one cycle.
- in_ready stays 1 in DATA; back-to-back bytes every cycle are supported.
- After word N, go to CHK.
- CHK: if the received byte equals the running XOR, go to DONE. On the next edge: cpu_start=1 for one cycle, cpu_hold=0, load_done=1. Otherwise go to ERR.
- ERR: load_err=1, cpu_hold stays 1, in_ready=1. Non-sync bytes are discarded; 0xA5 restarts at LEN_HI. Memory words already written are not rolled back.
- DONE: in_ready=cpu_halted. Bytes are accepted only while the processor has halted (HLT). An accepted 0xA5 starts a reload (cpu_hold=1 the next cycle); other accepted bytes are discarded.
- in_valid low stalls all states indefinitely; there is no timeout.
- Async reset mid-frame aborts the frame: outputs return to reset values, no further writes occur, and partial memory contents are left as written.
- cpu_start and mem_we are never high in the same cycle.

Test Plan:
- Stream A5 00 02 28 01 00 0A 28 02 00 14 1F, one byte per cycle -> mem_we pulses at addr 0 with 0x2801000A and addr 1 with 0x28020014, each one cycle after the 4th byte. cpu_start pulses once, cpu_hold falls, load_done=1.
- Same frame with CHK 0x1E -> both words are written, load_err=1, cpu_hold stays 1, no cpu_start pulse.
- Length 00 00, then length 04 01 (1025 words) -> immediate ERR after LEN_LO, no mem_we.
- Garbage bytes 00 FF 12 before A5, plus random in_valid gaps within a valid 9-word frame (MIPS test program 0x2801000A..0xFC000000) -> garbage is ignored and words land at addr 0..8 in order.
- After DONE with cpu_halted=0, present A5 -> in_ready=0 and no reload. Raise cpu_halted -> A5 is accepted and cpu_hold rises the next cycle.
- Assert rst after 2 data words of a 4-word frame -> all outputs return to reset values asynchronously, and no further mem_we occurs until a new frame.
